// File: rtl/qdr_mon_pkg.sv
// qdr_mon_pkg: shared types and defaults for the QDRII+ calibration monitor.
//   mon_state_e   : 3-bit FSM state, encodings fixed for the debug port
//   DEF_*         : default timeout / pulse / retry constants
//   cnt_width()   : counter width able to hold 0..n-1 (minimum 1 bit)
package qdr_mon_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_CAL  = 3'd0,
    ST_RETRY_RST = 3'd1,
    ST_RUN       = 3'd2,
    ST_FAIL      = 3'd3
  } mon_state_e;

  localparam int unsigned DEF_CAL_TIMEOUT_CYCLES = 2 ** 24;
  localparam int unsigned DEF_RST_PULSE_CYCLES   = 64;
  localparam int unsigned DEF_MAX_RETRY          = 3;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for signals asynchronous to clk.
//   clk, rst : destination clock, asynchronous active-high reset
//   d        : asynchronous input, WIDTH bits (each bit synchronized independently)
//   q        : synchronized output, two clk cycles of latency
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/qdr_cal_monitor.sv
// qdr_cal_monitor: calibration and data-integrity supervisor for the QDRII+ top.
// Times out a stalled calibration and requests a MIG reset retry, counts
// compare-error events while running, drives status LEDs and sticky flags.
//   sys_clk, sys_rst : clock, asynchronous active-high reset
//   cal_done         : MIG calibration complete (asynchronous)
//   compare_error    : traffic-generator mismatch (asynchronous)
//   mig_rst_req      : reset request to the upstream QDR top
//   led_ok, led_err  : health / error LEDs
//   err_count        : saturating count of compare-error rising edges in RUN
//   retry_cnt        : retries performed so far
//   state            : encoded FSM state (debug)
//   cal_lost         : sticky, set when calibration drops while in RUN
// Build option: QDR_CAL_MON_RETRY_EN enables the retry path; without it a
// calibration timeout goes straight to FAIL and mig_rst_req/retry_cnt stay 0.
module qdr_cal_monitor
  import qdr_mon_pkg::*;
#(
  parameter int unsigned CAL_TIMEOUT_CYCLES = DEF_CAL_TIMEOUT_CYCLES,
  parameter int unsigned RST_PULSE_CYCLES   = DEF_RST_PULSE_CYCLES,
  parameter int unsigned MAX_RETRY          = DEF_MAX_RETRY,
  parameter int unsigned ERR_CNT_WIDTH      = 16,
  parameter int unsigned BLINK_DIV_BITS     = 23
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     cal_done,
  input  logic                     compare_error,
  output logic                     mig_rst_req,
  output logic                     led_ok,
  output logic                     led_err,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic [3:0]               retry_cnt,
  output logic [2:0]               state,
  output logic                     cal_lost
);

  localparam int unsigned       TMR_W       = cnt_width(CAL_TIMEOUT_CYCLES);
  localparam int unsigned       PLS_W       = cnt_width(RST_PULSE_CYCLES);
  localparam logic [TMR_W-1:0]  TMR_LAST    = TMR_W'(CAL_TIMEOUT_CYCLES - 1);
  localparam logic [PLS_W-1:0]  PLS_LAST    = PLS_W'(RST_PULSE_CYCLES - 1);
  localparam logic [3:0]        RETRY_LIMIT = 4'(MAX_RETRY);

  logic cal_s, err_s;

  mon_state_e                 state_q, state_d;
  logic [TMR_W-1:0]           timer_q, timer_d;
  logic [PLS_W-1:0]           pulse_q, pulse_d;
  logic [3:0]                 retry_q, retry_d;
  logic [ERR_CNT_WIDTH-1:0]   err_cnt_q, err_cnt_d;
  logic                       err_flag_q, err_flag_d;
  logic                       cal_lost_q, cal_lost_d;
  logic                       err_prev_q, err_prev_d;
  logic [BLINK_DIV_BITS-1:0]  div_q, div_d;
  logic                       mig_rst_q, mig_rst_d;
  logic                       led_ok_q, led_ok_d;
  logic                       led_err_q, led_err_d;
  logic                       err_rise, blink;

  sync_2ff #(.WIDTH(1)) u_sync_cal (
    .clk (sys_clk),
    .rst (sys_rst),
    .d   (cal_done),
    .q   (cal_s)
  );

  sync_2ff #(.WIDTH(1)) u_sync_err (
    .clk (sys_clk),
    .rst (sys_rst),
    .d   (compare_error),
    .q   (err_s)
  );

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    pulse_d    = pulse_q;
    retry_d    = retry_q;
    err_cnt_d  = err_cnt_q;
    err_flag_d = err_flag_q;
    cal_lost_d = cal_lost_q;
    err_prev_d = err_s;
    div_d      = div_q + 1'b1;
    err_rise   = err_s & ~err_prev_q;

    case (state_q)
      ST_WAIT_CAL: begin
        timer_d = timer_q + 1'b1;
        if (cal_s) begin
          state_d = ST_RUN;
          timer_d = '0;
        end else if (timer_q == TMR_LAST) begin
          timer_d = '0;
`ifdef QDR_CAL_MON_RETRY_EN
          if (retry_q < RETRY_LIMIT) begin
            state_d = ST_RETRY_RST;
            pulse_d = '0;
          end else begin
            state_d = ST_FAIL;
          end
`else
          state_d = ST_FAIL;
`endif
        end
      end
      ST_RETRY_RST: begin
        pulse_d = pulse_q + 1'b1;
        if (pulse_q == PLS_LAST) begin
          state_d = ST_WAIT_CAL;
          retry_d = retry_q + 1'b1;
          timer_d = '0;
          pulse_d = '0;
        end
      end
      ST_RUN: begin
        // An error edge coinciding with loss of calibration is still counted.
        if (err_rise) begin
          err_flag_d = 1'b1;
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
        end
        if (!cal_s) begin
          state_d    = ST_WAIT_CAL;
          timer_d    = '0;
          cal_lost_d = 1'b1;
        end
      end
      ST_FAIL: ;
      default: state_d = ST_WAIT_CAL;
    endcase

    // Outputs are registered from next-state values so they line up with state_q.
    blink     = div_d[BLINK_DIV_BITS-1];
    led_ok_d  = 1'b0;
    led_err_d = 1'b0;
    case (state_d)
      ST_RUN:                    led_ok_d = ~err_flag_d;
      ST_WAIT_CAL, ST_RETRY_RST: led_ok_d = blink;
      default: ;
    endcase
    if (err_flag_d)                led_err_d = 1'b1;
    else if (state_d == ST_FAIL)   led_err_d = blink;

`ifdef QDR_CAL_MON_RETRY_EN
    mig_rst_d = (state_d == ST_RETRY_RST);
`else
    mig_rst_d = 1'b0;
`endif
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= ST_WAIT_CAL;
      timer_q    <= '0;
      pulse_q    <= '0;
      retry_q    <= '0;
      err_cnt_q  <= '0;
      err_flag_q <= 1'b0;
      cal_lost_q <= 1'b0;
      err_prev_q <= 1'b0;
      div_q      <= '0;
      mig_rst_q  <= 1'b0;
      led_ok_q   <= 1'b0;
      led_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      pulse_q    <= pulse_d;
      retry_q    <= retry_d;
      err_cnt_q  <= err_cnt_d;
      err_flag_q <= err_flag_d;
      cal_lost_q <= cal_lost_d;
      err_prev_q <= err_prev_d;
      div_q      <= div_d;
      mig_rst_q  <= mig_rst_d;
      led_ok_q   <= led_ok_d;
      led_err_q  <= led_err_d;
    end
  end

  assign mig_rst_req = mig_rst_q;
  assign led_ok      = led_ok_q;
  assign led_err     = led_err_q;
  assign err_count   = err_cnt_q;
  assign state       = state_q;
  assign cal_lost    = cal_lost_q;
`ifdef QDR_CAL_MON_RETRY_EN
  assign retry_cnt   = retry_q;
`else
  assign retry_cnt   = 4'd0;
`endif

endmodule

// File: tb/tb_qdr_cal_monitor.sv
`timescale 1ns/1ps
module tb_qdr_cal_monitor;

  localparam int unsigned T_CAL      = 100;
  localparam int unsigned T_PLS      = 8;
  localparam int unsigned N_RETRY    = 2;
  localparam int unsigned BLINK_BITS = 4;
  localparam int unsigned EW         = 4;
`ifdef QDR_CAL_MON_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif
  localparam int unsigned CNT_MAX    = (1 << EW) - 1;
  localparam int unsigned BLINK_PER  = 1 << BLINK_BITS;

  logic          sys_clk = 1'b0;
  logic          sys_rst;
  logic          cal_done;
  logic          compare_error;
  logic          mig_rst_req;
  logic          led_ok;
  logic          led_err;
  logic [EW-1:0] err_count;
  logic [3:0]    retry_cnt;
  logic [2:0]    state;
  logic          cal_lost;

  int total = 0;
  int bad   = 0;

  bit  rst_seen;
  int  fail_k, cur_w, exp_pulses, exp_fail, hi_cnt, flips, found, n_err, w, d;
  bit  prev;
  int  starts[$];
  int  widths[$];
  bit  smp[64];

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) if (mig_rst_req === 1'b1) rst_seen = 1'b1;

  qdr_cal_monitor #(
    .CAL_TIMEOUT_CYCLES (T_CAL),
    .RST_PULSE_CYCLES   (T_PLS),
    .MAX_RETRY          (N_RETRY),
    .ERR_CNT_WIDTH      (EW),
    .BLINK_DIV_BITS     (BLINK_BITS)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .cal_done      (cal_done),
    .compare_error (compare_error),
    .mig_rst_req   (mig_rst_req),
    .led_ok        (led_ok),
    .led_err       (led_err),
    .err_count     (err_count),
    .retry_cnt     (retry_cnt),
    .state         (state),
    .cal_lost      (cal_lost)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    sys_rst       = 1'b1;
    cal_done      = 1'b0;
    compare_error = 1'b0;
    tick(3);
    sys_rst  = 1'b0;
    rst_seen = 1'b0;
  endtask

  // Model expectation: saturating count of error pulses seen in RUN.
  function automatic int unsigned model_cnt(input int unsigned n);
    return (n > CNT_MAX) ? CNT_MAX : n;
  endfunction

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // ---- reset state ----
    sys_rst = 1'b1; cal_done = 1'b0; compare_error = 1'b0;
    tick(2);
    check_eq("rst_state",   state,       0);
    check_eq("rst_mig",     mig_rst_req, 0);
    check_eq("rst_led_ok",  led_ok,      0);
    check_eq("rst_led_err", led_err,     0);
    check_eq("rst_errcnt",  err_count,   0);
    check_eq("rst_retry",   retry_cnt,   0);
    check_eq("rst_callost", cal_lost,    0);
    sys_rst  = 1'b0;
    rst_seen = 1'b0;

    // ---- 1: calibration completes, 3-cycle latency to RUN ----
    tick($urandom_range(5, 60));
    cal_done = 1'b1;
    tick(2);
    check_eq("s1_pre_state", state, 0);
    tick(1);
    check_eq("s1_state",   state,   2);
    check_eq("s1_led_ok",  led_ok,  1);
    check_eq("s1_led_err", led_err, 0);
    tick(20);
    check_eq("s1_stay_run", state,    2);
    check_eq("s1_no_mig",   rst_seen, 0);

    // ---- 3: error pulses in RUN, saturating count ----
    compare_error = 1'b1;
    tick(1);
    check_eq("s3_lat_early", err_count, 0);
    tick(3);
    check_eq("s3_lat_late",  err_count, 1);
    compare_error = 1'b0;
    tick($urandom_range(3, 6));
    n_err = 1;
    for (int i = 1; i < 20; i++) begin
      compare_error = 1'b1;
      tick($urandom_range(3, 5));
      compare_error = 1'b0;
      tick($urandom_range(3, 6));
      n_err++;
      check_eq($sformatf("s3_cnt%0d", n_err), err_count, model_cnt(n_err));
    end
    check_eq("s3_sat",     err_count, CNT_MAX);
    check_eq("s3_led_err", led_err,   1);
    check_eq("s3_led_ok",  led_ok,    0);
    check_eq("s3_state",   state,     2);

    // ---- 4: calibration lost and regained ----
    cal_done = 1'b0;
    tick(3);
    check_eq("s4_state_wait", state,     0);
    check_eq("s4_callost",    cal_lost,  1);
    check_eq("s4_cnt_kept",   err_count, CNT_MAX);
    cal_done = 1'b1;
    tick(3);
    check_eq("s4_state_run",  state,    2);
    check_eq("s4_callost2",   cal_lost, 1);
    check_eq("s4_led_ok",     led_ok,   0);

    // ---- 5: reset mid-retry pulse (FAIL state when retry is disabled) ----
    cal_done = 1'b0;
    found = 0;
    for (int k = 0; k < 400 && found == 0; k++) begin
      tick(1);
`ifdef QDR_CAL_MON_RETRY_EN
      if (mig_rst_req === 1'b1) found = 1;
`else
      if (state === 3'd3) found = 1;
`endif
    end
    check_eq("s5_reached", found, 1);
`ifdef QDR_CAL_MON_RETRY_EN
    tick(3);
    check_eq("s5_mig_before", mig_rst_req, 1);
`endif
    #2 sys_rst = 1'b1;
    #1;
    check_eq("s5_mig",     mig_rst_req, 0);
    check_eq("s5_state",   state,       0);
    check_eq("s5_led_ok",  led_ok,      0);
    check_eq("s5_led_err", led_err,     0);
    check_eq("s5_errcnt",  err_count,   0);
    check_eq("s5_retry",   retry_cnt,   0);
    check_eq("s5_callost", cal_lost,    0);

    // ---- 6: error in WAIT_CAL ignored; health LED blinks ----
    apply_reset();
    tick($urandom_range(2, 10));
    compare_error = 1'b1;
    tick(3);
    compare_error = 1'b0;
    tick(6);
    check_eq("s6_errcnt",  err_count, 0);
    check_eq("s6_led_err", led_err,   0);
    check_eq("s6_state",   state,     0);
    hi_cnt = 0;
    for (int i = 0; i < 2 * BLINK_PER; i++) begin
      tick(1);
      if (led_ok === 1'b1) hi_cnt++;
    end
    check_eq("s6_blink_duty", hi_cnt, BLINK_PER);

    // ---- 7: error edge and calibration loss in the same cycle ----
    apply_reset();
    cal_done = 1'b1;
    tick(4);
    check_eq("s7_run", state, 2);
    compare_error = 1'b1;
    cal_done      = 1'b0;
    tick(3);
    check_eq("s7_cnt",     err_count, 1);
    check_eq("s7_state",   state,     0);
    check_eq("s7_callost", cal_lost,  1);
    check_eq("s7_led_err", led_err,   1);
    compare_error = 1'b0;

    // ---- 2: calibration never completes ----
    apply_reset();
    exp_pulses = RETRY_EN ? N_RETRY : 0;
    exp_fail   = (exp_pulses + 1) * T_CAL + exp_pulses * T_PLS;
    fail_k = -1; cur_w = 0; prev = 1'b0;
    starts.delete(); widths.delete();
    for (int k = 1; k <= 600 && fail_k < 0; k++) begin
      tick(1);
      if (mig_rst_req === 1'b1) begin
        if (!prev) starts.push_back(k);
        cur_w++;
      end else if (prev) begin
        widths.push_back(cur_w);
        cur_w = 0;
      end
      prev = (mig_rst_req === 1'b1);
      if (state === 3'd3) fail_k = k;
    end
    check_eq("s2_fail_window", (fail_k >= exp_fail && fail_k <= exp_fail + 4), 1);
    check_eq("s2_pulse_count", widths.size(), exp_pulses);
    foreach (widths[i]) check_eq($sformatf("s2_pulse_w%0d", i), widths[i], T_PLS);
    if (starts.size() > 0) check_eq("s2_first_start", starts[0], T_CAL);
    for (int i = 1; i < starts.size(); i++)
      check_eq($sformatf("s2_gap%0d", i), starts[i] - starts[i-1], T_CAL + T_PLS);
    check_eq("s2_retry",  retry_cnt, exp_pulses);
    check_eq("s2_led_ok", led_ok,    0);
    for (int i = 0; i < 2 * BLINK_PER; i++) begin
      tick(1);
      smp[i] = (led_err === 1'b1);
    end
    hi_cnt = 0;
    flips  = 0;
    for (int i = 0; i < 2 * BLINK_PER; i++) if (smp[i]) hi_cnt++;
    for (int i = 0; i + BLINK_PER / 2 < 2 * BLINK_PER; i++)
      if (smp[i] != smp[i + BLINK_PER / 2]) flips++;
    check_eq("s2_err_blink_duty", hi_cnt, BLINK_PER);
    check_eq("s2_err_blink_half", flips,  2 * BLINK_PER - BLINK_PER / 2);
    check_eq("s2_stay_fail", state, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
